// File: rtl/router_mem_arbiter_pkg.sv
// Shared encodings for the router memory-port arbiter: FSM states and burst direction.
package router_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_XFER  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

endpackage

// File: rtl/router_mem_arbiter_if.sv
// Controller-side request/grant bundle plus the buffer-RAM port driven by the arbiter.
interface router_mem_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 10
);
  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            read_req;
  logic [NUM_REQ-1:0]            write_req;
  logic [NUM_REQ*ADDR_WIDTH-1:0] src_addr;
  logic [NUM_REQ*ADDR_WIDTH-1:0] dst_addr;
  logic [NUM_REQ-1:0]            read_gnt;
  logic [NUM_REQ-1:0]            write_gnt;
  logic                          mem_rd_en;
  logic                          mem_wr_en;
  logic [ADDR_WIDTH-1:0]         mem_addr;
  logic [IDX_W-1:0]              xfer_owner;
  logic                          xfer_busy;
  logic                          xfer_done;

  modport master (
    output read_req, write_req, src_addr, dst_addr,
    input  read_gnt, write_gnt, mem_rd_en, mem_wr_en, mem_addr,
           xfer_owner, xfer_busy, xfer_done
  );

  modport slave (
    input  read_req, write_req, src_addr, dst_addr,
    output read_gnt, write_gnt, mem_rd_en, mem_wr_en, mem_addr,
           xfer_owner, xfer_busy, xfer_done
  );

endinterface

// File: rtl/router_mem_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping around.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic               valid_o,
  output logic [IDX_W-1:0]   idx_o
);

  // Scan farthest-first so the candidate closest to ptr_i is the last one written.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_i[(int'(ptr_i) + k) % NUM_REQ]) begin
        valid_o = 1'b1;
        idx_o   = IDX_W'((int'(ptr_i) + k) % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/router_mem_arbiter.sv
// Shares the packet-buffer memory port: round-robin grant, then a fixed-length burst
// from the winner's base address. All outputs come straight from registers.
module router_mem_arbiter
  import router_mem_arbiter_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int ADDR_WIDTH    = 10,
  parameter int NUMBER_PACKET = 19
) (
  input logic                 clk,
  input logic                 rst,
  router_mem_arbiter_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(NUMBER_PACKET + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUMBER_PACKET - 1);

  state_e                state_q;
  op_e                   op_q;
  logic [IDX_W-1:0]      rr_ptr_q;
  logic [IDX_W-1:0]      owner_q;
  logic [CNT_W-1:0]      beat_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [NUM_REQ-1:0]    rd_gnt_q;
  logic [NUM_REQ-1:0]    wr_gnt_q;
  logic                  rd_en_q;
  logic                  wr_en_q;
  logic                  busy_q;
  logic                  done_q;

  logic                  pick_valid;
  logic [IDX_W-1:0]      pick_idx;
  logic [NUM_REQ-1:0]    pick_onehot;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [IDX_W-1:0]      rr_ptr_d;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req_i   (bus.read_req | bus.write_req),
    .ptr_i   (rr_ptr_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  assign pick_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
  // Address arithmetic is left to wrap modulo 2^ADDR_WIDTH.
  assign addr_d      = base_q + ADDR_WIDTH'(beat_q + CNT_W'(1));
  assign rr_ptr_d    = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + IDX_W'(1);

  // Winner, direction and base are captured on the IDLE edge, so a request
  // dropped right after being sampled is still honoured in GRANT.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_READ;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      beat_q   <= '0;
      base_q   <= '0;
      addr_q   <= '0;
      rd_gnt_q <= '0;
      wr_gnt_q <= '0;
      rd_en_q  <= 1'b0;
      wr_en_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      rd_gnt_q <= '0;
      wr_gnt_q <= '0;
      done_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (pick_valid) begin
            owner_q <= pick_idx;
            busy_q  <= 1'b1;
            state_q <= ST_GRANT;
            if (bus.write_req[pick_idx]) begin
              op_q     <= OP_WRITE;
              wr_gnt_q <= pick_onehot;
              base_q   <= bus.dst_addr[int'(pick_idx)*ADDR_WIDTH +: ADDR_WIDTH];
            end else begin
              op_q     <= OP_READ;
              rd_gnt_q <= pick_onehot;
              base_q   <= bus.src_addr[int'(pick_idx)*ADDR_WIDTH +: ADDR_WIDTH];
            end
          end
        end
        ST_GRANT: begin
          beat_q  <= '0;
          addr_q  <= base_q;
          rd_en_q <= (op_q == OP_READ);
          wr_en_q <= (op_q == OP_WRITE);
          state_q <= ST_XFER;
        end
        ST_XFER: begin
          if (beat_q == LAST_BEAT) begin
            rd_en_q  <= 1'b0;
            wr_en_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            rr_ptr_q <= rr_ptr_d;
            state_q  <= ST_DONE;
          end else begin
            beat_q <= beat_q + CNT_W'(1);
            addr_q <= addr_d;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.read_gnt   = rd_gnt_q;
  assign bus.write_gnt  = wr_gnt_q;
  assign bus.mem_rd_en  = rd_en_q;
  assign bus.mem_wr_en  = wr_en_q;
  assign bus.mem_addr   = addr_q;
  assign bus.xfer_owner = owner_q;
  assign bus.xfer_busy  = busy_q;
  assign bus.xfer_done  = done_q;

endmodule

// File: tb/tb_router_mem_arbiter.sv
// Directed bench for router_mem_arbiter: reset abort, fairness, vector table of bursts, back-to-back.
module tb_router_mem_arbiter;

  localparam int NREQ = 4;
  localparam int AW   = 10;
  localparam int NP   = 19;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  router_mem_arbiter_if #(.NUM_REQ(NREQ), .ADDR_WIDTH(AW)) bus ();

  router_mem_arbiter #(
    .NUM_REQ       (NREQ),
    .ADDR_WIDTH    (AW),
    .NUMBER_PACKET (NP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         idx;
    logic       rd;
    logic       wr;
    logic [9:0] src;
    logic [9:0] dst;
    logic [3:0] expRdGnt;
    logic [3:0] expWrGnt;
    logic [1:0] expOwner;
    logic       expWrite;
    logic [9:0] expBase;
  } vec_t;

  vec_t vecs[6];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] rd, input logic [3:0] wr);
    bus.read_req  = rd;
    bus.write_req = wr;
  endtask

  task automatic setAddr(input int idx, input logic [9:0] src, input logic [9:0] dst);
    bus.src_addr[idx*AW +: AW] = src;
    bus.dst_addr[idx*AW +: AW] = dst;
  endtask

  function automatic logic [31:0] allOutputs();
    return 32'({bus.read_gnt, bus.write_gnt, bus.mem_rd_en, bus.mem_wr_en, bus.mem_addr,
                bus.xfer_owner, bus.xfer_busy, bus.xfer_done});
  endfunction

  // Called during an IDLE cycle with the request already driven; returns during the next IDLE cycle.
  task automatic checkBurst(input string tag, input logic [3:0] expRdGnt, input logic [3:0] expWrGnt,
                            input logic [1:0] expOwner, input logic expWrite, input logic [9:0] expBase,
                            input logic dropGranted);
    logic [9:0] a;
    @(posedge clk); #1;
    checkOutput({tag, " grant"},
                32'({bus.read_gnt, bus.write_gnt, bus.xfer_busy, bus.xfer_owner, bus.mem_rd_en, bus.mem_wr_en}),
                32'({expRdGnt, expWrGnt, 1'b1, expOwner, 1'b0, 1'b0}));
    if (dropGranted) begin
      if (expWrite) bus.write_req[expOwner] = 1'b0;
      else          bus.read_req[expOwner]  = 1'b0;
    end
    for (int b = 0; b < NP; b++) begin
      @(posedge clk); #1;
      a = expBase + 10'(b);
      checkOutput($sformatf("%s beat%0d", tag, b),
                  32'({bus.xfer_busy, bus.mem_rd_en, bus.mem_wr_en, bus.read_gnt, bus.write_gnt, bus.mem_addr}),
                  32'({1'b1, ~expWrite, expWrite, 4'b0, 4'b0, a}));
    end
    @(posedge clk); #1;
    checkOutput({tag, " done"},
                32'({bus.xfer_done, bus.xfer_busy, bus.mem_rd_en, bus.mem_wr_en, bus.read_gnt, bus.write_gnt}),
                32'({1'b1, 1'b0, 1'b0, 1'b0, 4'b0, 4'b0}));
    @(posedge clk); #1;
    checkOutput({tag, " idle"},
                32'({bus.xfer_done, bus.xfer_busy, bus.mem_rd_en, bus.mem_wr_en}), 32'(0));
  endtask

  initial begin
    int order[5];
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.src_addr = '0;
    bus.dst_addr = '0;
    applyStimulus(4'b0000, 4'b0000);

    vecs[0] = '{0, 1'b1, 1'b0, 10'h010, 10'h2AA, 4'b0001, 4'b0000, 2'd0, 1'b0, 10'h010};
    vecs[1] = '{2, 1'b1, 1'b1, 10'h050, 10'h100, 4'b0000, 4'b0100, 2'd2, 1'b1, 10'h100};
    vecs[2] = '{2, 1'b1, 1'b0, 10'h050, 10'h100, 4'b0100, 4'b0000, 2'd2, 1'b0, 10'h050};
    vecs[3] = '{3, 1'b1, 1'b0, 10'h3F8, 10'h000, 4'b1000, 4'b0000, 2'd3, 1'b0, 10'h3F8};
    vecs[4] = '{1, 1'b0, 1'b1, 10'h123, 10'h3FF, 4'b0000, 4'b0010, 2'd1, 1'b1, 10'h3FF};
    vecs[5] = '{0, 1'b1, 1'b1, 10'h020, 10'h030, 4'b0000, 4'b0001, 2'd0, 1'b1, 10'h030};

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset outputs", allOutputs(), 32'(0));
    rst = 1'b0;

    // Reset during beat 5 of a read burst from requester 1.
    setAddr(1, 10'h040, 10'h000);
    applyStimulus(4'b0010, 4'b0000);
    @(posedge clk); #1;
    checkOutput("abort grant", 32'({bus.read_gnt, bus.write_gnt}), 32'({4'b0010, 4'b0000}));
    applyStimulus(4'b0000, 4'b0000);
    for (int b = 0; b <= 5; b++) begin
      @(posedge clk); #1;
    end
    checkOutput("abort beat5", 32'({bus.mem_rd_en, bus.mem_addr}), 32'({1'b1, 10'h045}));
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("abort reset", allOutputs(), 32'(0));
    rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("abort quiet", allOutputs(), 32'(0));

    // All four hold write_req: grants must rotate 0,1,2,3,0 starting from the reset pointer.
    order = '{0, 1, 2, 3, 0};
    for (int i = 0; i < NREQ; i++) setAddr(i, 10'h000, 10'(10'h040 * (i + 1)));
    applyStimulus(4'b0000, 4'b1111);
    for (int g = 0; g < 5; g++) begin
      if (g == 4) begin
        checkBurst($sformatf("fair%0d", g), 4'b0000, 4'b0001 << order[g], 2'(order[g]), 1'b1,
                   10'(10'h040 * (order[g] + 1)), 1'b0);
      end else begin
        checkBurst($sformatf("fair%0d", g), 4'b0000, 4'b0001 << order[g], 2'(order[g]), 1'b1,
                   10'(10'h040 * (order[g] + 1)), 1'b0);
      end
    end
    applyStimulus(4'b0000, 4'b0000);

    // Single-requester bursts: read, write-over-read, deferred read, address wrap.
    for (int v = 0; v < 6; v++) begin
      logic [3:0] rdv;
      logic [3:0] wrv;
      rdv = '0;
      wrv = '0;
      rdv[vecs[v].idx] = vecs[v].rd;
      wrv[vecs[v].idx] = vecs[v].wr;
      setAddr(vecs[v].idx, vecs[v].src, vecs[v].dst);
      applyStimulus(rdv, wrv);
      checkBurst($sformatf("vec%0d", v), vecs[v].expRdGnt, vecs[v].expWrGnt, vecs[v].expOwner,
                 vecs[v].expWrite, vecs[v].expBase, 1'b1);
    end
    applyStimulus(4'b0000, 4'b0000);

    // Requester 1 arrives mid-burst and must wait until the IDLE after requester 0's DONE.
    setAddr(0, 10'h200, 10'h000);
    setAddr(1, 10'h000, 10'h300);
    applyStimulus(4'b0001, 4'b0000);
    @(posedge clk); #1;
    checkOutput("b2b grant0", 32'({bus.read_gnt, bus.write_gnt}), 32'({4'b0001, 4'b0000}));
    applyStimulus(4'b0000, 4'b0000);
    for (int b = 0; b < NP; b++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("b2b beat%0d", b),
                  32'({bus.mem_rd_en, bus.mem_wr_en, bus.write_gnt, bus.mem_addr}),
                  32'({1'b1, 1'b0, 4'b0000, 10'(10'h200 + b)}));
      if (b == 3) applyStimulus(4'b0000, 4'b0010);
    end
    @(posedge clk); #1;
    checkOutput("b2b done0", 32'({bus.xfer_done, bus.mem_rd_en, bus.mem_wr_en, bus.write_gnt}),
                32'({1'b1, 1'b0, 1'b0, 4'b0000}));
    @(posedge clk); #1;
    checkOutput("b2b idle", 32'({bus.xfer_done, bus.mem_rd_en, bus.mem_wr_en, bus.write_gnt}), 32'(0));
    checkBurst("b2b req1", 4'b0000, 4'b0010, 2'd1, 1'b1, 10'h300, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
